pulse_rate_meter: RTL and testbench
===================================

// Module: pulse_rate_meter
// PURPOSE
//  Spirometer turbine-pulse rate meter, directly downstream of the edge detector.
//  Counts single-cycle posedge pulses (qualified by the shared sample tick iCE)
//  over fixed gate windows of GATE_TICKS ticks.
//  Publishes each window's count with a one-cycle valid strobe for the flow/volume stage.
// PARAMETERS
//  GATE_TICKS  1000  iCE ticks per gate window (>=2)
//  CNT_W       16    width of pulse count / result
// PORTS
//  iClk       in   1      system clock, all logic on rising edge
//  iReset     in   1      reset, asynchronous, active-low
//  iCE        in   1      sample tick, same enable that drives the edge detector
//  iPosedge   in   1      edge-detector pulse; counted only when iCE=1
//  iStart     in   1      level/pulse: begin continuous measurement
//  iStop      in   1      pulse: abort measurement, return to idle
//  oCount     out  CNT_W  pulse count of last completed window (held)
//  oValid     out  1      one-cycle strobe, oCount updated this cycle
//  oBusy      out  1      1 while in ARM or GATE
//  oOverflow  out  1      sticky per window: count saturated in last completed window
//  oPeak      out  CNT_W  max window count since clear (PEAK_HOLD_EN only)
// BEHAVIOUR
//  - Reset (iReset=0, async): state IDLE; oCount=0, oValid=0, oBusy=0, oOverflow=0,
//    oPeak=0, tick/pulse accumulators 0. Mid-window reset discards partial window.
//  - FSM: IDLE -> ARM on iStart=1 & iStop=0. ARM -> GATE on next iCE=1 (window aligned
//    to a tick; no pulse counted in ARM). GATE stays until iStop.
//  - GATE, each cycle with iCE=1: tick counter +1; if iPosedge=1, pulse acc +1,
//    saturating at 2^CNT_W-1 (sets internal ovf flag).
//  - Window close: iCE=1 with tick counter==GATE_TICKS-1. The same-tick pulse belongs
//    to the closing window. Next cycle: oCount=final acc, oOverflow=ovf, oValid=1 for
//    exactly 1 cycle. Acc, ovf and tick counter reload to 0 in the same edge, so the
//    next window starts with no lost tick.
//  - iStop=1 in ARM/GATE: -> IDLE next cycle; partial window dropped, no oValid;
//    oCount/oOverflow keep last published values. iStop on closing cycle: stop wins,
//    no oValid.
//  - iStart & iStop together: stop wins. iStart in ARM/GATE: ignored.
//  - iPosedge while iCE=0 or in IDLE/ARM: ignored.
//  - oBusy is registered: 1 from cycle after iStart accept until cycle after stop.
//  - Latency: oValid asserts 1 clk after closing iCE tick.
// CONFIGURATION
//  PULSE_PEAK_HOLD_EN defined: register oPeak updates with oValid when the new
//    oCount > oPeak. Adds input iPeakClr (1 bit): zeroes oPeak next cycle.
//    iPeakClr coincident with oValid loads oPeak=new oCount.
//  Not defined: no peak register, oPeak tied to 0, no iPeakClr port.
// STRUCTURE
//  Shared package pkg_espiro: FSM state encoding (ST_IDLE=2'd0, ST_ARM=2'd1,
//    ST_GATE=2'd2); default GATE_TICKS/CNT_W constants shared with flow stage.
//  Tick counter width = $clog2(GATE_TICKS).
//  One natural sub-module: gate_tick_counter (tick count + terminal-count flag,
//    sync clear, enable=iCE).
//  Pulse accumulator and FSM stay in this module.
// TESTING  (GATE_TICKS=10, CNT_W=4, iCE every 4th clk unless noted)
//  1. Reset, iStart; 3 pulses in window 1 and 7 in window 2 ->
//     oValid twice, oCount=3 then 7, oOverflow=0.
//  2. Pulse on the closing tick of window 1 -> counted in window 1;
//     window 2 with no pulses -> oCount=0, oValid still strobes.
//  3. 20 pulses in one window (iCE every clk, iPosedge=1) ->
//     oCount=15, oOverflow=1; next window with 2 pulses -> oCount=2, oOverflow=0.
//  4. iStop after 5 ticks with 4 pulses -> oBusy=0 next clk, no oValid,
//     oCount keeps previous value; iStart & iStop same clk -> stays IDLE.
//  5. Async iReset=0 mid-window (not clock-aligned) -> all outputs 0 immediately;
//     after release, IDLE until iStart.
//  6. PULSE_PEAK_HOLD_EN: windows 5, 9, 4 -> oPeak 5, 9, 9;
//     iPeakClr -> 0; iPeakClr with oValid(6) -> oPeak=6.

Source files
------------

// File: rtl/pkg_espiro.sv
// Shared definitions for the spirometer pulse-rate path.
//   state_t         : gate FSM encoding, also decoded by the flow/volume stage
//   DEF_GATE_TICKS  : default iCE ticks per gate window
//   DEF_CNT_W       : default pulse count / result width
package pkg_espiro;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2
  } state_t;

  localparam int DEF_GATE_TICKS = 1000;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/pulse_rate_meter_gate_tick_counter.sv
// gate_tick_counter: counts iCE ticks inside one gate window.
// Implemented as a down-counter holding the number of ticks still to go;
// oTc flags the closing tick of the window. A value of GATE_TICKS-1 means
// "no ticks elapsed yet".
// Ports:
//   iClk    in  system clock
//   iReset  in  asynchronous active-low reset
//   iClr    in  synchronous clear (restart window)
//   iEn     in  tick enable (iCE)
//   oTc     out 1 while the current tick is the last one of the window
module gate_tick_counter #(
  parameter int GATE_TICKS = 1000
) (
  input  logic iClk,
  input  logic iReset,
  input  logic iClr,
  input  logic iEn,
  output logic oTc
);

  localparam int TW = $clog2(GATE_TICKS);
  localparam logic [TW-1:0] LOAD = TW'(GATE_TICKS - 1);

  logic [TW-1:0] remain;

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      remain <= LOAD;
    end else if (iClr) begin
      remain <= LOAD;
    end else if (iEn) begin
      // Reload on the closing tick so the next window loses no tick.
      remain <= oTc ? LOAD : remain - 1'b1;
    end
  end

  assign oTc = (remain == '0);

endmodule

// File: rtl/pulse_rate_meter.sv
// pulse_rate_meter: counts edge-detector pulses (qualified by iCE) over
// fixed gate windows and publishes each window's count with a strobe.
// Optional feature macro: PULSE_PEAK_HOLD_EN (peak-hold register + iPeakClr).
// Ports:
//   iClk      in  system clock
//   iReset    in  asynchronous active-low reset
//   iCE       in  sample tick
//   iPosedge  in  edge pulse, counted only with iCE in GATE
//   iStart    in  begin continuous measurement
//   iStop     in  abort measurement (wins over iStart and window close)
//   iPeakClr  in  clear peak (only with PULSE_PEAK_HOLD_EN)
//   oCount    out count of last completed window
//   oValid    out one-cycle strobe with each new oCount
//   oBusy     out measurement active (ARM or GATE), registered
//   oOverflow out last completed window saturated
//   oPeak     out max window count since clear (0 without peak hold)
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | not measuring, waiting for iStart
// ARM     | start accepted, waiting for a tick to align window
// GATE    | counting ticks and pulses, windows back-to-back
module pulse_rate_meter
  import pkg_espiro::*;
#(
  parameter int GATE_TICKS = DEF_GATE_TICKS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iCE,
  input  logic             iPosedge,
  input  logic             iStart,
  input  logic             iStop,
`ifdef PULSE_PEAK_HOLD_EN
  input  logic             iPeakClr,
`endif
  output logic [CNT_W-1:0] oCount,
  output logic             oValid,
  output logic             oBusy,
  output logic             oOverflow,
  output logic [CNT_W-1:0] oPeak
);

  state_t state, state_nxt;

  logic             tc;
  logic             gate_clr;
  logic             close;
  logic             pulse;
  logic             acc_max;
  logic [CNT_W-1:0] acc, acc_upd;
  logic             ovf, ovf_upd;

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (iStart && !iStop) state_nxt = ST_ARM;
      ST_ARM: begin
        if (iStop)    state_nxt = ST_IDLE;
        else if (iCE) state_nxt = ST_GATE;
      end
      ST_GATE: if (iStop) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counter is held at window start outside GATE, so the ARM->GATE tick
  // is not part of the first window.
  assign gate_clr = (state != ST_GATE) || iStop;

  gate_tick_counter #(
    .GATE_TICKS(GATE_TICKS)
  ) u_gate_tick_counter (
    .iClk  (iClk),
    .iReset(iReset),
    .iClr  (gate_clr),
    .iEn   (iCE),
    .oTc   (tc)
  );

  assign close = (state == ST_GATE) && iCE && tc && !iStop;
  assign pulse = (state == ST_GATE) && iCE && iPosedge;

  // acc_upd includes a pulse on the closing tick, so it is what gets published.
  assign acc_max = (acc == '1);
  assign acc_upd = (pulse && !acc_max) ? acc + 1'b1 : acc;
  assign ovf_upd = ovf || (pulse && acc_max);

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (gate_clr || close) begin
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= acc_upd;
      ovf <= ovf_upd;
    end
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      oCount    <= '0;
      oOverflow <= 1'b0;
      oValid    <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      oValid <= close;
      oBusy  <= (state_nxt != ST_IDLE);
      if (close) begin
        oCount    <= acc_upd;
        oOverflow <= ovf_upd;
      end
    end
  end

`ifdef PULSE_PEAK_HOLD_EN
  // A clear coinciding with a publish restarts the peak at the new count.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      oPeak <= '0;
    end else if (close) begin
      if (iPeakClr || (acc_upd > oPeak)) oPeak <= acc_upd;
    end else if (iPeakClr) begin
      oPeak <= '0;
    end
  end
`else
  assign oPeak = '0;
`endif

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Directed bench for pulse_rate_meter. Main instance: GATE_TICKS=10, CNT_W=4.
// A second instance with GATE_TICKS=20 shares the stimulus so that a single
// window can hold more pulses than the 4-bit count can represent.
// Peak-hold steps run only when PULSE_PEAK_HOLD_EN is defined.
module tb_pulse_rate_meter;

  logic iClk = 1'b0;
  logic iReset = 1'b0;
  logic iCE = 1'b0;
  logic iPosedge = 1'b0;
  logic iStart = 1'b0;
  logic iStop = 1'b0;
  logic iPeakClr = 1'b0;

  logic [3:0] count1, peak1, count2, peak2;
  logic       valid1, busy1, ovf1, valid2, busy2, ovf2;

  int checks = 0;
  int failures = 0;

  int         v1, v2;
  logic [3:0] c1, c2;
  logic       o1, o2;

  always #5 iClk = ~iClk;

  pulse_rate_meter #(.GATE_TICKS(10), .CNT_W(4)) u_dut (
    .iClk(iClk), .iReset(iReset), .iCE(iCE), .iPosedge(iPosedge),
    .iStart(iStart), .iStop(iStop),
`ifdef PULSE_PEAK_HOLD_EN
    .iPeakClr(iPeakClr),
`endif
    .oCount(count1), .oValid(valid1), .oBusy(busy1),
    .oOverflow(ovf1), .oPeak(peak1)
  );

  pulse_rate_meter #(.GATE_TICKS(20), .CNT_W(4)) u_ovf (
    .iClk(iClk), .iReset(iReset), .iCE(iCE), .iPosedge(iPosedge),
    .iStart(iStart), .iStop(iStop),
`ifdef PULSE_PEAK_HOLD_EN
    .iPeakClr(iPeakClr),
`endif
    .oCount(count2), .oValid(valid2), .oBusy(busy2),
    .oOverflow(ovf2), .oPeak(peak2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns at the following negedge with
  // strobes from both instances recorded.
  task automatic cyc(input logic ce, input logic pos);
    iCE = ce;
    iPosedge = pos;
    @(negedge iClk);
    if (valid1) begin v1++; c1 = count1; o1 = ovf1; end
    if (valid2) begin v2++; c2 = count2; o2 = ovf2; end
  endtask

  task automatic clr_mon();
    v1 = 0; v2 = 0;
  endtask

  // n ticks, pulse on tick i when mask[i]; gap non-tick clocks after each
  // tick carry iPosedge=noise, which must never be counted.
  task automatic window(input int n, input logic [31:0] mask, input logic noise, input int gap);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, mask[i]);
      repeat (gap) cyc(1'b0, noise);
    end
  endtask

  task automatic arm();
    iStart = 1'b1;
    cyc(1'b0, 1'b0);
    iStart = 1'b0;
    chk("busy_after_start", busy1, 1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);  // aligning tick, pulse must be ignored
    repeat (3) cyc(1'b0, 1'b0);
  endtask

  initial begin
    v1 = 0; v2 = 0; c1 = '0; c2 = '0; o1 = 1'b0; o2 = 1'b0;
    #12;
    chk("rst_count", count1, 0);
    chk("rst_valid", valid1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_peak", peak1, 0);
    @(negedge iClk);
    iReset = 1'b1;
    repeat (3) cyc(1'b1, 1'b1);
    chk("idle_busy", busy1, 0);
    chk("idle_novalid", v1, 0);

    // windows of 3 and 7 pulses
    arm();
    clr_mon(); window(10, 32'h091, 1'b1, 3);
    chk("w1_nvalid", v1, 1); chk("w1_count", c1, 3); chk("w1_ovf", o1, 0);
    clr_mon(); window(10, 32'h3F8, 1'b1, 3);
    chk("w2_nvalid", v1, 1); chk("w2_count", c1, 7); chk("w2_ovf", o1, 0);

    // pulse on closing tick only, then empty window
    clr_mon(); window(10, 32'h200, 1'b1, 3);
    chk("close_tick_count", c1, 1);
    clr_mon(); window(10, 32'h000, 1'b1, 3);
    chk("empty_nvalid", v1, 1); chk("empty_count", c1, 0);
    chk("gate_busy", busy1, 1);

    // overflow on the 20-tick instance, every clock a tick
    iStop = 1'b1; cyc(1'b0, 1'b0); iStop = 1'b0;
    chk("stop_busy", busy1, 0);
    arm();
    clr_mon(); window(20, 32'hFFFFF, 1'b0, 0);
    chk("sat_nvalid", v2, 1); chk("sat_count", c2, 15); chk("sat_ovf", o2, 1);
    chk("ten_nvalid", v1, 2); chk("ten_count", c1, 10); chk("ten_ovf", o1, 0);
    clr_mon(); window(20, 32'h3, 1'b0, 0);
    chk("after_sat_count", c2, 2); chk("after_sat_ovf", o2, 0);

    // stop mid-window keeps last result
    clr_mon(); window(10, 32'h03F, 1'b0, 3);
    chk("pre_stop_count", c1, 6);
    clr_mon(); window(5, 32'h00F, 1'b0, 3);
    iStop = 1'b1; cyc(1'b0, 1'b0); iStop = 1'b0;
    chk("midstop_busy", busy1, 0);
    window(12, 32'hFFF, 1'b0, 3);
    chk("midstop_novalid", v1, 0);
    chk("midstop_count_held", count1, 6);

    // start and stop together
    iStart = 1'b1; iStop = 1'b1; cyc(1'b0, 1'b0); iStart = 1'b0; iStop = 1'b0;
    chk("startstop_busy", busy1, 0);
    repeat (4) cyc(1'b1, 1'b0);
    chk("startstop_idle", busy1, 0);

    // stop on the closing tick: no publish
    arm();
    clr_mon(); window(9, 32'h1, 1'b0, 3);
    iStop = 1'b1; cyc(1'b1, 1'b1); iStop = 1'b0;
    repeat (4) cyc(1'b0, 1'b0);
    chk("stop_close_novalid", v1, 0);
    chk("stop_close_busy", busy1, 0);
    chk("stop_close_count", count1, 6);

    // asynchronous reset mid-window
    arm();
    window(3, 32'h7, 1'b0, 3);
    #2 iReset = 1'b0;
    #1;
    chk("arst_count", count1, 0);
    chk("arst_busy", busy1, 0);
    chk("arst_valid", valid1, 0);
    @(negedge iClk);
    iReset = 1'b1;
    clr_mon(); window(12, 32'hFFF, 1'b0, 3);
    chk("arst_idle_busy", busy1, 0);
    chk("arst_idle_novalid", v1, 0);

`ifdef PULSE_PEAK_HOLD_EN
    arm();
    window(10, 32'h01F, 1'b0, 3); chk("peak_5", peak1, 5);
    window(10, 32'h1FF, 1'b0, 3); chk("peak_9", peak1, 9);
    window(10, 32'h00F, 1'b0, 3); chk("peak_hold_9", peak1, 9);
    iPeakClr = 1'b1; cyc(1'b0, 1'b0); iPeakClr = 1'b0;
    chk("peak_clr", peak1, 0);
    window(10, 32'h0FF, 1'b0, 3); chk("peak_8", peak1, 8);
    clr_mon(); window(9, 32'h03F, 1'b0, 3);
    iPeakClr = 1'b1; cyc(1'b1, 1'b0); iPeakClr = 1'b0;
    chk("peak_clr_valid_strobe", v1, 1);
    chk("peak_clr_valid", peak1, 6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
